// File: rtl/snn_tick_scheduler.sv
// Run sequencer for snn_core: fetches per-tick event rows, drives the core one tick
// at a time, and returns spike rows through a credit-protected valid/ready FIFO.
module snn_tick_scheduler #(
    parameter int F     = 48,
    parameter int N     = 96,
    parameter int AW    = 16,
    parameter int TW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [TW-1:0] t_len,
    input  logic [AW-1:0] ev_base,
    input  logic          stdp_req,
    input  logic          abort,
    output logic          ev_rd,
    output logic [AW-1:0] ev_addr,
    input  logic [F-1:0]  ev_rdata,
    output logic          core_clr,
    output logic          core_en,
    output logic [F-1:0]  core_event_vec,
    output logic          core_stdp_enable,
    input  logic [N-1:0]  core_spikes_vec,
    output logic          spk_valid,
    input  logic          spk_ready,
    output logic [N-1:0]  spk_data,
    output logic [TW-1:0] spk_tick,
    output logic          spk_last,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int UW = CW + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] t_len_q, t_len_d;
    logic [AW-1:0] base_q, base_d;
    logic          stdp_q, stdp_d;
    logic [TW-1:0] issue_q, issue_d;
    logic [TW-1:0] push_tick_q, push_tick_d;
    logic          ev_rd_q, ev_rd_d;
    logic [AW-1:0] ev_addr_q, ev_addr_d;
    logic          s1_q, s1_d;
    logic          core_en_q, core_en_d;
    logic [F-1:0]  core_event_vec_q, core_event_vec_d;
    logic          s3_q, s3_d;
    logic          core_clr_q, core_clr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0]  fifo_data_q [DEPTH];
    logic [TW-1:0] fifo_tick_q [DEPTH];
    logic          fifo_last_q [DEPTH];

    logic          push, pop, fifo_we, credit_ok;
    logic [UW-1:0] in_use;

    // Stream handshake: a row transfers on every cycle with spk_valid & spk_ready; while
    // spk_valid is high and spk_ready low the head row and its tags are held unchanged.
    assign spk_valid = (count_q != '0);
    assign pop       = spk_valid & spk_ready;
    assign push      = s3_q;
    assign fifo_we   = push & ~abort;
    assign spk_data  = spk_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign spk_tick  = spk_valid ? fifo_tick_q[rd_ptr_q] : '0;
    assign spk_last  = spk_valid & fifo_last_q[rd_ptr_q];

    // Every issued tick owns a FIFO slot from ev_rd until its row is popped.
    assign in_use    = UW'(count_q) + UW'(s3_q) + UW'(core_en_q) + UW'(s1_q) + UW'(ev_rd_q);
    assign credit_ok = (in_use < UW'(DEPTH));

    assign ev_rd            = ev_rd_q;
    assign ev_addr          = ev_addr_q;
    assign core_clr         = core_clr_q;
    assign core_en          = core_en_q;
    assign core_event_vec   = core_event_vec_q;
    assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign core_stdp_enable = busy & stdp_q;
    assign dbg_state        = state_q;

    always_comb begin
        state_d          = state_q;
        t_len_d          = t_len_q;
        base_d           = base_q;
        stdp_d           = stdp_q;
        issue_d          = issue_q;
        push_tick_d      = push_tick_q;
        ev_rd_d          = 1'b0;
        ev_addr_d        = ev_addr_q;
        s1_d             = ev_rd_q;
        core_en_d        = s1_q;
        core_event_vec_d = s1_q ? ev_rdata : '0;
        s3_d             = core_en_q;
        core_clr_d       = 1'b0;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + PW'(1);
            push_tick_d = push_tick_q + TW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    t_len_d     = t_len;
                    base_d      = ev_base;
                    stdp_d      = stdp_req;
                    issue_d     = '0;
                    push_tick_d = '0;
                    core_clr_d  = 1'b1;
                    state_d     = (t_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    ev_rd_d   = 1'b1;
                    ev_addr_d = base_q + AW'(issue_q);
                    issue_d   = issue_q + TW'(1);
                    if (issue_q == t_len_q - TW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && spk_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the run outright: pipeline and FIFO contents are discarded.
        if (abort) begin
            state_d          = S_IDLE;
            ev_rd_d          = 1'b0;
            s1_d             = 1'b0;
            core_en_d        = 1'b0;
            core_event_vec_d = '0;
            s3_d             = 1'b0;
            core_clr_d       = 1'b0;
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= S_IDLE;
            t_len_q          <= '0;
            base_q           <= '0;
            stdp_q           <= 1'b0;
            issue_q          <= '0;
            push_tick_q      <= '0;
            ev_rd_q          <= 1'b0;
            ev_addr_q        <= '0;
            s1_q             <= 1'b0;
            core_en_q        <= 1'b0;
            core_event_vec_q <= '0;
            s3_q             <= 1'b0;
            core_clr_q       <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            state_q          <= state_d;
            t_len_q          <= t_len_d;
            base_q           <= base_d;
            stdp_q           <= stdp_d;
            issue_q          <= issue_d;
            push_tick_q      <= push_tick_d;
            ev_rd_q          <= ev_rd_d;
            ev_addr_q        <= ev_addr_d;
            s1_q             <= s1_d;
            core_en_q        <= core_en_d;
            core_event_vec_q <= core_event_vec_d;
            s3_q             <= s3_d;
            core_clr_q       <= core_clr_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
        end
    end

    // Storage needs no reset: the head outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_data_q[wr_ptr_q] <= core_spikes_vec;
            fifo_tick_q[wr_ptr_q] <= push_tick_q;
            fifo_last_q[wr_ptr_q] <= (push_tick_q == t_len_q - TW'(1));
        end
    end

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// Bench for snn_tick_scheduler: event RAM and core models, per-cycle monitor,
// scoreboard of expected spike rows, table-driven and random runs.
module tb_snn_tick_scheduler;
    localparam int F     = 48;
    localparam int N     = 96;
    localparam int AW    = 16;
    localparam int TW    = 16;
    localparam int DEPTH = 4;
    localparam int EW    = N + TW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] t_len = '0;
    logic [AW-1:0] ev_base = '0;
    logic          stdp_req = 1'b0;
    logic          abort = 1'b0;
    logic          ev_rd;
    logic [AW-1:0] ev_addr;
    logic [F-1:0]  ev_rdata = '0;
    logic          core_clr;
    logic          core_en;
    logic [F-1:0]  core_event_vec;
    logic          core_stdp_enable;
    logic [N-1:0]  core_spikes_vec = '0;
    logic          spk_valid;
    logic          spk_ready = 1'b0;
    logic [N-1:0]  spk_data;
    logic [TW-1:0] spk_tick;
    logic          spk_last;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    snn_tick_scheduler #(.F(F), .N(N), .AW(AW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .start(start), .t_len(t_len), .ev_base(ev_base),
        .stdp_req(stdp_req), .abort(abort), .ev_rd(ev_rd), .ev_addr(ev_addr),
        .ev_rdata(ev_rdata), .core_clr(core_clr), .core_en(core_en),
        .core_event_vec(core_event_vec), .core_stdp_enable(core_stdp_enable),
        .core_spikes_vec(core_spikes_vec), .spk_valid(spk_valid), .spk_ready(spk_ready),
        .spk_data(spk_data), .spk_tick(spk_tick), .spk_last(spk_last),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [F-1:0] ram_row(input logic [AW-1:0] a);
        return {a ^ 16'hA5C3, ~a, a};
    endfunction

    // ---------------- event RAM and core models ----------------
    logic [15:0] core_k = '0;

    always @(posedge clk) begin
        if (ev_rd) ev_rdata <= ram_row(ev_addr);
    end

    always @(posedge clk) begin
        if (core_clr) core_k <= '0;
        if (core_en) begin
            core_spikes_vec <= {core_event_vec, core_k, 31'b0, core_stdp_enable};
            core_k <= core_k + 16'd1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] exp_q[$];
    int            ev_cyc[$];
    int            en_cyc[$];
    int            cyc = 0, ev_idx = 0, pops_run = 0;
    int            n_ev_rd = 0, n_core_en = 0, n_done = 0, n_clr = 0, n_pop = 0;
    int            accept_cyc = -1, done_cyc = -1, last_pop_cyc = -1;
    logic [AW-1:0] cur_base = '0;
    logic          cur_stdp = 1'b0;
    logic [AW-1:0] exp_addr;
    logic          prev_hold = 1'b0, prev_abort = 1'b0;
    logic [EW-1:0] prev_head = '0;
    int            ready_pct = 100;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            if (start && !abort && !busy && !done) accept_cyc = cyc;
            if (core_clr) begin
                n_clr++;
                ev_idx   = 0;
                pops_run = 0;
            end
            if (ev_rd) begin
                exp_addr = cur_base + AW'(ev_idx);
                chk("ev_addr", ev_addr, exp_addr);
                ev_idx++;
                n_ev_rd++;
                ev_cyc.push_back(cyc);
                chk("credit_outstanding", (ev_idx - pops_run <= DEPTH), 1'b1);
            end
            if (core_en) begin
                n_core_en++;
                en_cyc.push_back(cyc);
            end else begin
                chk("event_vec_idle", core_event_vec, '0);
            end
            chk("stdp_enable", core_stdp_enable, busy & cur_stdp);
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_busy", busy, 1'b0);
            end
            if (prev_hold && !prev_abort)
                chk("head_hold", {spk_valid, spk_data, spk_tick, spk_last}, {1'b1, prev_head});
            if (spk_valid && spk_ready) begin
                if (exp_q.size() == 0) chk("pop_extra_qsize", exp_q.size(), 1);
                else chk("pop_row", {spk_data, spk_tick, spk_last}, exp_q.pop_front());
                n_pop++;
                pops_run++;
                last_pop_cyc = cyc;
            end
            prev_hold  = spk_valid && !spk_ready;
            prev_head  = {spk_data, spk_tick, spk_last};
            prev_abort = abort;
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            spk_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic begin_run(input logic [TW-1:0] t, input logic [AW-1:0] b, input logic s);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        n_ev_rd = 0; n_core_en = 0; n_done = 0; n_clr = 0; n_pop = 0;
        ev_cyc.delete(); en_cyc.delete();
        accept_cyc = -1; done_cyc = -1; last_pop_cyc = -1;
        cur_base = b;
        cur_stdp = s;
        for (int i = 0; i < int'(t); i++) begin
            a = b + AW'(i);
            exp_q.push_back({ram_row(a), 16'(i), 31'b0, s, TW'(i), (i == int'(t) - 1)});
        end
        t_len = t; ev_base = b; stdp_req = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [TW-1:0] t, input logic [AW-1:0] b, input logic s);
        @(posedge clk);
        #1;
        t_len = t; ev_base = b; stdp_req = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_done == 0) chk("done_timeout", n_done, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_run(input int e_ev, input int e_en, input int e_pop);
        chk("n_ev_rd", n_ev_rd, e_ev);
        chk("n_core_en", n_core_en, e_en);
        chk("n_pop", n_pop, e_pop);
        chk("n_done", n_done, 1);
        chk("n_core_clr", n_clr, 1);
        chk("exp_left", exp_q.size(), 0);
    endtask

    task automatic check_all_zero();
        chk("zero_ctrl", {ev_rd, ev_addr, core_clr, core_en, core_stdp_enable, spk_valid,
                          spk_tick, spk_last, busy, done}, '0);
        chk("zero_event_vec", core_event_vec, '0);
        chk("zero_spk_data", spk_data, '0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [TW-1:0] t;
        logic [AW-1:0] base;
        logic          stdp;
        int            rdy;
        int            e_ev;
        int            e_en;
        int            e_pop;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int clr_before;
        int k;
        logic [TW-1:0] rt;
        logic [AW-1:0] rb;
        logic rs;

        vecs[0] = '{16'd4,  16'h0000, 1'b0, 100, 4,  4,  4};
        vecs[1] = '{16'd1,  16'h0100, 1'b1, 100, 1,  1,  1};
        vecs[2] = '{16'd0,  16'h0005, 1'b0, 100, 0,  0,  0};
        vecs[3] = '{16'd4,  16'hFFFE, 1'b0, 100, 4,  4,  4};
        vecs[4] = '{16'd7,  16'h0123, 1'b1, 50,  7,  7,  7};
        vecs[5] = '{16'd16, 16'hFFF8, 1'b0, 30,  16, 16, 16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_all_zero();

        for (int i = 0; i < 6; i++) begin
            ready_pct = vecs[i].rdy;
            begin_run(vecs[i].t, vecs[i].base, vecs[i].stdp);
            wait_done(60 * int'(vecs[i].t) + 100);
            check_run(vecs[i].e_ev, vecs[i].e_en, vecs[i].e_pop);
        end

        // Back-to-back issue and pipeline timing with a free-running consumer.
        ready_pct = 100;
        begin_run(16'd4, 16'h0000, 1'b0);
        wait_done(200);
        check_run(4, 4, 4);
        if (ev_cyc.size() == 4 && en_cyc.size() == 4) begin
            chk("ev_rd_consecutive", ev_cyc[3] - ev_cyc[0], 3);
            chk("core_en_offset", en_cyc[0] - ev_cyc[0], 2);
            chk("core_en_consecutive", en_cyc[3] - en_cyc[0], 3);
        end
        chk("done_after_last_pop", done_cyc - last_pop_cyc, 1);

        // Zero-length run.
        begin_run(16'd0, 16'h0009, 1'b0);
        wait_done(50);
        check_run(0, 0, 0);
        chk("zero_len_latency", done_cyc - accept_cyc, 1);

        // Stalled consumer: credit limits issue to the FIFO depth.
        ready_pct = 0;
        begin_run(16'd10, 16'h0040, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_core_en", n_core_en, DEPTH);
        chk("stall_ev_rd", n_ev_rd, DEPTH);
        chk("stall_valid", spk_valid, 1'b1);
        ready_pct = 100;
        wait_done(600);
        check_run(10, 10, 10);

        // Abort mid-run, then a fresh run.
        begin_run(16'd10, 16'h0200, 1'b1);
        k = 0;
        while (ev_idx < 5 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("abort_reach_tick5", (ev_idx >= 5), 1'b1);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", spk_valid, 1'b0);
        chk("abort_core_en", core_en, 1'b0);
        repeat (20) @(posedge clk);
        chk("abort_no_done", n_done, 0);

        clr_before = n_clr;
        @(posedge clk);
        #1 begin start = 1'b1; abort = 1'b1; t_len = 16'd3; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        chk("abort_beats_start_busy", busy, 1'b0);
        chk("abort_beats_start_clr", n_clr - clr_before, 0);

        begin_run(16'd3, 16'h0010, 1'b0);
        wait_done(200);
        check_run(3, 3, 3);

        // STDP held through the run; a start during busy is ignored.
        ready_pct = 50;
        begin_run(16'd8, 16'h0777, 1'b1);
        repeat (6) @(posedge clk);
        pulse_start(16'd2, 16'h1234, 1'b0);
        wait_done(600);
        check_run(8, 8, 8);
        @(negedge clk);
        chk("stdp_after_done", core_stdp_enable, 1'b0);

        // Reset in the middle of a run clears every output at once.
        ready_pct = 100;
        begin_run(16'd10, 16'h0300, 1'b1);
        repeat (8) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_all_zero();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        begin_run(16'd5, 16'h0400, 1'b0);
        wait_done(300);
        check_run(5, 5, 5);

        // Randomised runs.
        for (int i = 0; i < 8; i++) begin
            rt = TW'($urandom_range(1, 24));
            rb = AW'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            ready_pct = $urandom_range(15, 100);
            begin_run(rt, rb, rs);
            wait_done(60 * int'(rt) + 100);
            check_run(int'(rt), int'(rt), int'(rt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d want 0", 1);
        $fatal(1, "global timeout");
    end

endmodule
